// File: rtl/rr_pkt_mux.sv
`default_nettype none
// ============================================================================
// Module      : rr_pkt_mux
// Description : Packet-level multiplexer placed downstream of a round-robin
//               arbiter (rr_arb). It presents the input valids as requests,
//               waits for a registered one-hot grant, then locks onto the
//               granted channel and forwards whole packets (no beat
//               interleaving) to a single output stream. After the beat that
//               carries 'last' it drops all requests for one cycle so the
//               arbiter clears its grant and rotates to the next channel.
//
// Ports       : clk        - clock shared with the arbiter
//               rst        - asynchronous, active-high reset
//               req_bus    - request vector driven to the arbiter
//               grant_bus  - registered grant from the arbiter (one-hot/zero)
//               in_valid   - per-channel beat valid
//               in_data    - per-channel data, channel i at [i*DW +: DW]
//               in_last    - per-channel end-of-packet
//               in_ready   - per-channel beat accept
//               out_valid  - output beat valid
//               out_data   - output beat data
//               out_last   - output end-of-packet
//               out_ready  - downstream accept
//               grant_err  - sticky flag, grant seen with >1 bit set
//
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pkt_mux #(
    parameter int NREQ = 4,
    parameter int DW   = 32
) (
    input  logic                clk,
    input  logic                rst,
    output logic [NREQ-1:0]     req_bus,
    input  logic [NREQ-1:0]     grant_bus,
    input  logic [NREQ-1:0]     in_valid,
    input  logic [NREQ*DW-1:0]  in_data,
    input  logic [NREQ-1:0]     in_last,
    output logic [NREQ-1:0]     in_ready,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    output logic                out_last,
    input  logic                out_ready,
    output logic                grant_err
);

    localparam int c_SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_XFER = 2'd1;
    localparam logic [1:0] c_GAP  = 2'd2;

    logic [1:0]      r_state;
    logic [c_SW-1:0] r_sel;
    logic            r_grant_err;

    logic            w_grant_multi;
    logic            w_grant_one;
    logic            w_grant_hit;
    logic [c_SW-1:0] w_grant_idx;
    logic [NREQ-1:0] w_sel_onehot;
    logic            w_sel_valid;
    logic            w_sel_last;
    logic [DW-1:0]   w_sel_data;
    logic            w_last_done;

    // Grant decode. Clearing the lowest set bit leaves a non-zero value only
    // when two or more bits are set.
    always_comb begin
        w_grant_multi = (grant_bus & (grant_bus - NREQ'(1))) != '0;
        w_grant_one   = (grant_bus != '0) && !w_grant_multi;
        w_grant_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_bus[i]) begin
                w_grant_idx = c_SW'(i);
            end
        end
        // A grant only starts a packet if the granted channel still has a beat.
        w_grant_hit   = w_grant_one && ((grant_bus & in_valid) != '0);
    end

    // Selected-channel view of the input streams.
    always_comb begin
        w_sel_onehot = '0;
        w_sel_valid  = 1'b0;
        w_sel_last   = 1'b0;
        w_sel_data   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_sel == c_SW'(i)) begin
                w_sel_onehot[i] = 1'b1;
                w_sel_valid     = in_valid[i];
                w_sel_last      = in_last[i];
                w_sel_data      = in_data[i*DW +: DW];
            end
        end
        w_last_done = (r_state == c_XFER) && w_sel_valid && out_ready && w_sel_last;
    end

    // Output path is purely combinational from state/sel so the forwarded
    // stream adds no latency. During XFER the request is pinned to the
    // selected channel, which keeps the arbiter's grant from moving.
    always_comb begin
        req_bus   = '0;
        in_ready  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = w_sel_data;
        if (!rst) begin
            case (r_state)
                c_IDLE: begin
                    req_bus = in_valid;
                end
                c_XFER: begin
                    req_bus   = w_sel_onehot;
                    out_valid = w_sel_valid;
                    out_last  = w_sel_last;
                    in_ready  = out_ready ? w_sel_onehot : '0;
                end
                default: begin
                    req_bus = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_sel       <= '0;
            r_grant_err <= 1'b0;
        end else begin
            if (w_grant_multi) begin
                r_grant_err <= 1'b1;
            end
            case (r_state)
                c_IDLE: begin
                    if (w_grant_hit) begin
                        r_sel   <= w_grant_idx;
                        r_state <= c_XFER;
                    end
                end
                c_XFER: begin
                    if (w_last_done) begin
                        r_state <= c_GAP;
                    end
                end
                c_GAP: begin
                    // Requests are low for this one cycle so the arbiter
                    // drops its grant and advances its pointer.
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign grant_err = r_grant_err;

endmodule
`default_nettype wire

// File: doc/rr_pkt_mux.md
# rr_pkt_mux

Packet-level multiplexer that sits directly downstream of `rr_arb`: it drives the arbiter's `req_bus` from NREQ input streams and consumes the registered `grant_bus` to forward whole packets, never interleaving beats, onto one output stream. It locks the granted channel for the full packet, ends on `last`, and then releases the arbiter so round-robin rotation proceeds.

## Interface
- `NREQ`, 4: number of input channels; must match the arbiter's NREQ.
- `DW`, 32: data width per beat.

- `clk`  in  1  single clock for the block and its arbiter.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_bus`  out  NREQ  request vector to `rr_arb`.
- `grant_bus`  in  NREQ  registered grant from `rr_arb`; expected one-hot or zero.
- `in_valid`  in  NREQ  per-channel beat valid.
- `in_data`  in  NREQ*DW  channel i occupies bits [i*DW +: DW].
- `in_last`  in  NREQ  per-channel end-of-packet flag.
- `in_ready`  out  NREQ  per-channel beat accept.
- `out_valid`  out  1  output beat valid.
- `out_data`  out  DW  output beat data.
- `out_last`  out  1  output end-of-packet.
- `out_ready`  in  1  downstream accept.
- `grant_err`  out  1  sticky flag: grant_bus seen with more than one bit set.

## Operation
- A beat transfers when valid and ready are both high on the same `clk` edge, on both ports. Input valid/data/last are held until the beat is accepted.
- `sel` is a registered channel index, log2(NREQ) bits wide, minimum 1.
- FSM states are IDLE, XFER and GAP; state and `sel` are registered.
- IDLE:
  - `req_bus` equals `in_valid`.
  - When `grant_bus` has exactly one bit i set and `in_valid[i]` is 1, the block latches `sel`=i and moves to XFER.
  - A zero grant, or a grant to a channel whose valid is low, keeps the block in IDLE.
- XFER:
  - `req_bus` is one-hot(`sel`), so the arbiter cannot move the grant mid-packet.
  - `out_valid`=`in_valid[sel]`, `out_data`=channel `sel` data, `out_last`=`in_last[sel]`.
  - `in_ready[sel]`=`out_ready`; all other `in_ready` bits are 0.
  - The output path is combinational, with no added latency.
  - The block moves to GAP when a beat with `in_last[sel]`=1 is accepted.
- GAP: lasts one cycle. `req_bus`=0, which lets the arbiter clear its grant and advance its pointer. Next state is IDLE.
- Outside XFER, `out_valid`=0 and all `in_ready` are 0.
- `grant_err` sets when `grant_bus` has two or more bits set in any cycle. It clears only on `rst`.
  - A multi-bit grant in IDLE is ignored, and the block stays in IDLE.
  - In XFER, `grant_bus` is not used for data selection.
- Single-beat packet (valid with last on the first beat): XFER lasts one accepted beat, then GAP.
- Backpressure: `out_ready`=0 holds XFER indefinitely with no data change. `in_valid[sel]` dropping mid-packet gives `out_valid`=0 and the block stays in XFER.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State becomes IDLE, `sel`=0, `grant_err`=0.
  - `req_bus` is forced to 0 while `rst` is high.
  - `out_valid`, `out_last` and all `in_ready` are 0. `out_data` is don't-care.
- Start latency, with the arbiter's one-cycle registered grant:
  - cycle 0: in IDLE, `in_valid[i]` rises and `req_bus[i]`=1.
  - cycle 1: `grant_bus[i]`=1 and `sel` is latched.
  - cycle 2: XFER, `out_valid`=1.
- Packet-to-packet turnaround, counted from the edge that accepts the last beat (cycle n):
  - n+1 is GAP.
  - n+2 is IDLE with grant=0.
  - n+3 is IDLE with the new grant.
  - n+4 is the first beat of the next packet, giving 3 dead cycles.
- Reset mid-packet:
  - The packet is truncated and no `out_last` is emitted.
  - The upstream source remains responsible for its own state.
  - After `rst` falls, arbitration restarts from IDLE.
- Fairness comes from `rr_arb`. With all channels continuously requesting, grants rotate 0,1,2,3,0…

## Test plan
- Reset: hold `rst` for 3 cycles with all `in_valid`=4'b1111 -> `req_bus`=0, `out_valid`=0, `in_ready`=0, `grant_err`=0; after release, `req_bus`=4'b1111 in the first cycle.
- Single channel: channel 2 sends 4 beats 0x20..0x23, last on beat 4, with `out_ready`=1 -> `out_valid` rises 2 cycles after `in_valid[2]`; output is 0x20..0x23 with `out_last` on 0x23; `req_bus`=4'b0100 throughout XFER.
- No interleave, with `rr_arb` instantiated: channels 0 and 2 each send 3-beat packets (0xA0.., 0xC0..) -> each packet is output contiguously, the grants alternate, and there are exactly 3 dead cycles between packets.
- Full load: all 4 channels send repeated 2-beat packets tagged with the channel number -> channel order rotates 0,1,2,3,0; no beat is lost or duplicated over 16 packets.
- Backpressure: `out_ready` toggles 1,0,0,1 during a 5-beat packet -> `in_ready[sel]` mirrors `out_ready`, data stays stable while stalled, and the 5 beats arrive in order.
- Error and abort:
  - Force `grant_bus`=4'b0011 for one cycle in IDLE -> `grant_err`=1 and stays 1, and the block stays in IDLE.
  - Assert `rst` during beat 2 of a 4-beat packet -> `out_valid`=0 immediately and `grant_err` clears.
